burst_cycle_sequencer: RTL

//  Issuing side of the burst-count path. On a trigger it plays exactly Burst_N waveform periods, then stops.

---
 rtl/burst_pkg.sv | 16 +
 rtl/burst_trig_edge.sv | 19 +
 rtl/burst_cycle_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/burst_pkg.sv
// Shared types and constants for the burst cycle sequencer.
package burst_pkg;

  localparam int CNT_W_DEF = 20;
  localparam int IDX_W_DEF = 16;

  // A period length of zero is played as a single-sample period.
  localparam int LEN_MIN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/burst_trig_edge.sv
// Registered rising-edge detector for the burst trigger input.
module burst_trig_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic i_trig,
  output logic o_rise
);

  logic r_trig_q;

  // Hold the previous trigger sample; cleared by reset so a high level after reset counts as an edge.
  always_ff @(posedge Clock) begin
    if (!Reset) r_trig_q <= 1'b0;
    else        r_trig_q <= i_trig;
  end

  assign o_rise = i_trig & ~r_trig_q;

endmodule

// File: rtl/burst_cycle_sequencer.sv
// Burst cycle sequencer: on a trigger edge plays Burst_N periods of Period_Len samples,
// driving the waveform RAM index, the output gate and one Cycle_Start pulse per period.
// Optional macro BURST_TRIG_DELAY_EN adds a Trig_Delay input and a DELAY state between
// the trigger and the first sample.
//
//   state    | meaning
//   ST_IDLE  | waiting for a trigger edge, all outputs quiet
//   ST_DELAY | trigger accepted, counting Trig_Delay clocks with the gate closed
//   ST_RUN   | playing samples, gate open
module burst_cycle_sequencer
  import burst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Trigger,
  input  logic             Stop,
  input  logic [CNT_W-1:0] Burst_N,
  input  logic [IDX_W-1:0] Period_Len,
`ifdef BURST_TRIG_DELAY_EN
  input  logic [CNT_W-1:0] Trig_Delay,
`endif
  output logic             Gate,
  output logic             Cycle_Start,
  output logic [IDX_W-1:0] Sample_Idx,
  output logic [CNT_W-1:0] Cycles_Left,
  output logic             Busy,
  output logic             Done
);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] r_len, w_len_nxt;
  logic [CNT_W-1:0] r_cycles_left, w_cycles_left_nxt;
  logic             r_done, w_done_nxt;
`ifdef BURST_TRIG_DELAY_EN
  logic [CNT_W-1:0] r_dly, w_dly_nxt;
  logic [CNT_W-1:0] r_burst_n, w_burst_n_nxt;
`endif

  logic             w_start;
  logic [IDX_W-1:0] w_len_eff;
  logic             w_last_idx;
  logic             w_final;

  burst_trig_edge u_trig_edge (
    .Clock  (Clock),
    .Reset  (Reset),
    .i_trig (Trigger),
    .o_rise (w_start)
  );

  assign w_len_eff  = (Period_Len == '0) ? IDX_W'(LEN_MIN) : Period_Len;
  assign w_last_idx = (r_idx == (r_len - IDX_W'(1)));
  // Infinite mode keeps Cycles_Left at 0, so it can never look like the final period.
  assign w_final    = w_last_idx && (r_cycles_left == CNT_W'(1));

  // State and datapath registers; reset overrides everything, including mid-burst.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_len         <= '0;
      r_cycles_left <= '0;
      r_done        <= 1'b0;
`ifdef BURST_TRIG_DELAY_EN
      r_dly         <= '0;
      r_burst_n     <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_len         <= w_len_nxt;
      r_cycles_left <= w_cycles_left_nxt;
      r_done        <= w_done_nxt;
`ifdef BURST_TRIG_DELAY_EN
      r_dly         <= w_dly_nxt;
      r_burst_n     <= w_burst_n_nxt;
`endif
    end
  end

  // Next-state and next-datapath logic; Stop takes priority over completion.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_len_nxt         = r_len;
    w_cycles_left_nxt = r_cycles_left;
    w_done_nxt        = 1'b0;
`ifdef BURST_TRIG_DELAY_EN
    w_dly_nxt         = r_dly;
    w_burst_n_nxt     = r_burst_n;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start && !Stop) begin
          w_len_nxt = w_len_eff;
          w_idx_nxt = '0;
`ifdef BURST_TRIG_DELAY_EN
          w_burst_n_nxt = Burst_N;
          w_dly_nxt     = Trig_Delay;
          if (Trig_Delay != '0) begin
            w_state_nxt       = ST_DELAY;
            w_cycles_left_nxt = '0;
          end else begin
            w_state_nxt       = ST_RUN;
            w_cycles_left_nxt = Burst_N;
          end
`else
          w_state_nxt       = ST_RUN;
          w_cycles_left_nxt = Burst_N;
`endif
        end
      end
      ST_DELAY: begin
`ifdef BURST_TRIG_DELAY_EN
        if (Stop) begin
          w_state_nxt       = ST_IDLE;
          w_idx_nxt         = '0;
          w_cycles_left_nxt = '0;
          w_dly_nxt         = '0;
        end else if (r_dly <= CNT_W'(1)) begin
          w_state_nxt       = ST_RUN;
          w_idx_nxt         = '0;
          w_cycles_left_nxt = r_burst_n;
          w_dly_nxt         = '0;
        end else begin
          w_dly_nxt = r_dly - CNT_W'(1);
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_RUN: begin
        if (Stop) begin
          w_state_nxt       = ST_IDLE;
          w_idx_nxt         = '0;
          w_cycles_left_nxt = '0;
        end else if (w_final) begin
          w_state_nxt       = ST_IDLE;
          w_idx_nxt         = '0;
          w_cycles_left_nxt = '0;
          w_done_nxt        = 1'b1;
        end else if (w_last_idx) begin
          w_idx_nxt = '0;
          if (r_cycles_left != '0) w_cycles_left_nxt = r_cycles_left - CNT_W'(1);
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_idx_nxt         = '0;
        w_cycles_left_nxt = '0;
      end
    endcase
  end

  assign Gate        = (r_state == ST_RUN);
  assign Cycle_Start = (r_state == ST_RUN) && (r_idx == '0);
  assign Sample_Idx  = r_idx;
  assign Cycles_Left = r_cycles_left;
  assign Busy        = (r_state != ST_IDLE);
  assign Done        = r_done;

endmodule
